// File: rtl/muldiv_seq_if.sv
// Handshake/bus bundle between the decode/writeback stage and the
// iterative RV32M multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1, rs2, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, rs1, rs2, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer.
// Multiply is shift-add on operand magnitudes, divide is restoring
// shift-subtract; signs are applied in a single FIX cycle afterwards.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed
// overflow and multiply-by-zero finish straight from IDLE into DONE.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  localparam logic [XLEN-1:0] MIN_C  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES_C = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_C = {XLEN{1'b0}};

  // Result of the architecturally defined corner cases (divide ops only;
  // a multiply by zero is simply zero). op[1] selects remainder vs quotient.
  function automatic logic [XLEN-1:0] special_res(input logic [2:0] op,
                                                  input logic dz,
                                                  input logic [XLEN-1:0] a);
    if (!op[2])     return ZERO_C;
    else if (dz)    return op[1] ? a : ONES_C;
    else            return op[1] ? ZERO_C : MIN_C;
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     b_q, b_d;          // |rs2|
  logic [XLEN-1:0]     rs1_q, rs1_d;      // rs1 as presented, for rem-by-zero
  logic                neg_q, neg_d;      // product / quotient negate
  logic                rneg_q, rneg_d;    // remainder negate (dividend sign)
  logic                dz_q, dz_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;      // {hi, lo} product or {rem, quot}
  logic [XLEN-1:0]     result_q, result_d;

  logic                neg_a_s, neg_b_s, dz_in_s, ovf_in_s;
  logic [XLEN-1:0]     mag_a_s, mag_b_s;
  logic [XLEN:0]       sum_s, rem_sh_s, diff_s;
  logic [2*XLEN-1:0]   mul_step_s, div_step_s, prod_s;
  logic [XLEN-1:0]     quot_s, rem_s, fix_res_s;
  logic                busy_s;
`ifdef MULDIV_EARLY_OUT_EN
  logic                early_s;
`endif

  // Operand decode at acceptance: signedness, magnitudes and special flags.
  always_comb begin
    neg_a_s  = (bus.op == 3'd1 || bus.op == 3'd2 || bus.op == 3'd4 || bus.op == 3'd6)
               & bus.rs1[XLEN-1];
    neg_b_s  = (bus.op == 3'd1 || bus.op == 3'd4 || bus.op == 3'd6) & bus.rs2[XLEN-1];
    mag_a_s  = neg_a_s ? (ZERO_C - bus.rs1) : bus.rs1;
    mag_b_s  = neg_b_s ? (ZERO_C - bus.rs2) : bus.rs2;
    dz_in_s  = (bus.rs2 == ZERO_C);
    ovf_in_s = (bus.op == 3'd4 || bus.op == 3'd6) && (bus.rs1 == MIN_C) && (bus.rs2 == ONES_C);
`ifdef MULDIV_EARLY_OUT_EN
    early_s  = bus.op[2] ? (dz_in_s | ovf_in_s)
                         : ((bus.rs1 == ZERO_C) | (bus.rs2 == ZERO_C));
`endif
  end

  // One iteration of shift-add multiply and restoring divide, plus FIX-stage sign fixup.
  always_comb begin
    sum_s      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    mul_step_s = {sum_s, acc_q[XLEN-1:1]};
    rem_sh_s   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff_s     = rem_sh_s - {1'b0, b_q};
    if (diff_s[XLEN]) begin
      div_step_s = {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_step_s = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    prod_s = neg_q  ? -acc_q : acc_q;
    quot_s = neg_q  ? (ZERO_C - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_s  = rneg_q ? (ZERO_C - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    if (!op_q[2]) begin
      fix_res_s = (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else if (dz_q || ovf_q) begin
      fix_res_s = special_res(op_q, dz_q, rs1_q);
    end else begin
      fix_res_s = op_q[1] ? rem_s : quot_s;
    end
  end

  // Next-state and datapath updates; flush beats start, DONE always completes.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    rs1_d    = rs1_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.start) begin
          op_d    = bus.op;
          b_d     = mag_b_s;
          rs1_d   = bus.rs1;
          neg_d   = neg_a_s ^ neg_b_s;
          rneg_d  = neg_a_s;
          dz_d    = dz_in_s;
          ovf_d   = ovf_in_s;
          cnt_d   = CNT_W'(XLEN-1);
          acc_d   = {ZERO_C, mag_a_s};
          state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (early_s) begin
            state_d  = DONE;
            result_d = special_res(bus.op, dz_in_s, bus.rs1);
          end else begin
            state_d  = CALC;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = op_q[2] ? div_step_s : mul_step_s;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
      end
      FIX: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          result_d = fix_res_s;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      b_q      <= ZERO_C;
      rs1_q    <= ZERO_C;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      result_q <= ZERO_C;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      rs1_q    <= rs1_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy_s     = (state_q == CALC) || (state_q == FIX);
  assign bus.busy   = busy_s;
  assign bus.done   = (state_q == DONE);
  assign bus.stall  = (bus.start && (state_q == IDLE)) || busy_s;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: spec vector table, random ops
// against a reference model, and flush / reset / held-start sequences.
module tb_muldiv_seq;

  localparam logic [31:0] MIN_C = 32'h8000_0000;

  logic clk;
  logic reset;
  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] sb_q [$];
  int          lat_q [$];
  logic [31:0] last_exp;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] xa, xb, p;
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == MIN_C) && (b == 32'hFFFF_FFFF);
    xa  = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    xb  = (op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p   = xa * xb;
    case (op)
      3'd0:          return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 32'd0)  return 32'hFFFF_FFFF;
        else if (ovf)    return MIN_C;
        else             return 32'(sa / sb);
      end
      3'd5:          return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0)  return a;
        else if (ovf)    return 32'd0;
        else             return 32'(sa % sb);
      end
      default:       return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit sp;
    bit en;
    sp = op[2] ? ((b == 32'd0) || ((op == 3'd4 || op == 3'd6) && a == MIN_C && b == 32'hFFFF_FFFF))
               : ((a == 32'd0) || (b == 32'd0));
`ifdef MULDIV_EARLY_OUT_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return (sp && en) ? 1 : 34;
  endfunction

  // Drive a request (call at a negedge with the DUT idle) and record expectations.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    sb_q.push_back(exp);
    lat_q.push_back(exp_latency(op, a, b));
  endtask

  // Wait for done after an issue; scrambles operand inputs while running.
  task automatic wait_done(input string name);
    int          cyc;
    int          lat;
    logic [31:0] exp;
    lat = lat_q.pop_front();
    exp = sb_q.pop_front();
    @(negedge clk);
    cyc       = 1;
    bus.start = 1'b0;
    bus.rs1   = $urandom;
    bus.rs2   = $urandom;
    bus.op    = 3'($urandom_range(0, 7));
    while (bus.done !== 1'b1 && cyc < 200) begin
      chk({name, " busy"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      cyc++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles, required %0d", name, cyc, lat);
    end else begin
      chk({name, " latency"}, 32'(cyc), 32'(lat));
      chk({name, " stall_in_done"}, 32'(bus.stall), 32'd0);
      chk({name, " result"}, bus.result, exp);
    end
    last_exp = exp;
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_exp  = 32'd0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.rs1   = 32'd0;
    bus.rs2   = 32'd0;
    bus.flush = 1'b0;

    vecs[0] = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1] = '{3'd1, MIN_C,         MIN_C,         32'h4000_0000};
    vecs[2] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[4] = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[5] = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[6] = '{3'd5, 32'd7,         32'd0,         32'hFFFF_FFFF};
    vecs[7] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    vecs[8] = '{3'd4, MIN_C,         32'hFFFF_FFFF, MIN_C};
    vecs[9] = '{3'd6, MIN_C,         32'hFFFF_FFFF, 32'd0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset busy",   32'(bus.busy),  32'd0);
    chk("reset done",   32'(bus.done),  32'd0);
    chk("reset stall",  32'(bus.stall), 32'd0);
    chk("reset result", bus.result,     32'd0);

    // Spec vector table.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_done($sformatf("vec%0d", i));
    end

    // Random operations against the reference model.
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      issue(op, a, b, ref_model(op, a, b));
      wait_done($sformatf("rand%0d", i));
    end

    // Flush in the middle of DIVU 100/7.
    bus.start = 1'b1; bus.op = 3'd5; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      chk("flush pre done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy",   32'(bus.busy), 32'd0);
    chk("flush done",   32'(bus.done), 32'd0);
    chk("flush result", bus.result,    last_exp);
    @(negedge clk);
    chk("flush done c12", 32'(bus.done), 32'd0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    wait_done("after_flush");

    // Flush together with start in IDLE: request is dropped.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.rs1 = 32'd7; bus.rs2 = 32'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start busy", 32'(bus.busy), 32'd0);
    chk("flush_start done", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("flush_start done2", 32'(bus.done), 32'd0);
    chk("flush_start result", bus.result, last_exp);

    // Reset in cycle 20 of a DIV.
    bus.start = 1'b1; bus.op = 3'd4; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid busy",   32'(bus.busy),  32'd0);
    chk("rst_mid done",   32'(bus.done),  32'd0);
    chk("rst_mid stall",  32'(bus.stall), 32'd0);
    chk("rst_mid result", bus.result,     32'd0);
    for (int c = 0; c < 20; c++) begin
      chk("rst_mid no_done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    last_exp = 32'd0;

    // start held high: second op accepted only in the cycle after DONE.
    begin
      int          cyc;
      int          lat;
      logic [31:0] exp;
      issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      lat = lat_q.pop_front();
      exp = sb_q.pop_front();
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (bus.done !== 1'b1 && cyc < 100);
      chk("held latency", 32'(cyc), 32'(lat));
      chk("held stall_in_done", 32'(bus.stall), 32'd0);
      chk("held result", bus.result, exp);
      @(negedge clk);
      chk("held accept busy",  32'(bus.busy),  32'd0);
      chk("held accept stall", 32'(bus.stall), 32'd1);
      chk("held accept done",  32'(bus.done),  32'd0);
      issue(3'd5, 32'd100, 32'd7, 32'd14);
      wait_done("held_second");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
